// File: rtl/led_fade_sched.sv
// Three-channel LED colour sequencer: walks an 8-entry colour table, fading each
// PWM channel toward the next colour and holding it for a programmable time.
module led_fade_sched #(
  parameter int PWM_WIDTH  = 8,
  parameter int PRESCALE   = 50000,
  parameter int HOLD_TICKS = 500,
  parameter int STEP       = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   EN,
  input  logic                   LOAD_WE,
  input  logic [2:0]             LOAD_ADDR,
  input  logic [3*PWM_WIDTH-1:0] LOAD_DATA,
  output logic [2:0]             LEDs,
  output logic                   BUSY,
  output logic [2:0]             STEP_IDX
);

  localparam int W  = PWM_WIDTH;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [W-1:0]  DUTY_FULL = {W{1'b1}};
  localparam logic [W-1:0]  CNT_LAST  = DUTY_FULL - W'(1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [W:0]    STEP_V    = (W+1)'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    cnt;
  logic [PW-1:0]   pre;
  logic [HW-1:0]   hold;
  logic [W-1:0]    cur_red, cur_grn, cur_blu;
  logic [W-1:0]    app_red, app_grn, app_blu;
  logic [W-1:0]    tgt_red, tgt_grn, tgt_blu;
  logic [3*W-1:0]  tbl [8];
  logic            tick;
  logic            at_tgt;
  logic [2:0]      next_idx;
  logic [3*W-1:0]  entry_now;
  logic [3*W-1:0]  entry_next;

  // One step of a channel toward its target in W+1-bit arithmetic, clamped at the target.
  function automatic logic [W-1:0] approach(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0] up;
    logic [W:0] dn;
    up = {1'b0, cur} + STEP_V;
    dn = {1'b0, cur} - STEP_V;
    if (cur < tgt) begin
      approach = (up > {1'b0, tgt}) ? tgt : up[W-1:0];
    end else if (cur > tgt) begin
      approach = (dn[W] || (dn < {1'b0, tgt})) ? tgt : dn[W-1:0];
    end else begin
      approach = cur;
    end
  endfunction

  // Entry k lights R, G, B fully according to bits 0, 1, 2 of k.
  function automatic logic [3*W-1:0] default_entry(input logic [2:0] k);
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    r = k[0] ? DUTY_FULL : '0;
    g = k[1] ? DUTY_FULL : '0;
    b = k[2] ? DUTY_FULL : '0;
    return {r, g, b};
  endfunction

  // Fade tick, arrival detection and table read ports.
  always_comb begin
    tick       = 1'b0;
    at_tgt     = 1'b0;
    next_idx   = STEP_IDX + 3'd1;
    entry_now  = tbl[STEP_IDX];
    entry_next = tbl[next_idx];
    if ((state != IDLE) && (pre == PRE_LAST)) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
    if ((cur_red == tgt_red) && (cur_grn == tgt_grn) && (cur_blu == tgt_blu)) begin
      at_tgt = 1'b1;
    end else begin
      at_tgt = 1'b0;
    end
  end

  // PWM period counter, period-aligned duty sampling and active-low LED drive.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt     <= '0;
      app_red <= '0;
      app_grn <= '0;
      app_blu <= '0;
      LEDs    <= 3'b111;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + W'(1);
      if (cnt == '0) begin
        app_red <= cur_red;
        app_grn <= cur_grn;
        app_blu <= cur_blu;
      end
      LEDs <= {~(cnt < app_blu), ~(cnt < app_grn), ~(cnt < app_red)};
    end
  end

  // Sequencer FSM, prescaler, hold timer and colour table.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      BUSY     <= 1'b0;
      STEP_IDX <= 3'd0;
      pre      <= '0;
      hold     <= '0;
      cur_red  <= '0;
      cur_grn  <= '0;
      cur_blu  <= '0;
      tgt_red  <= '0;
      tgt_grn  <= '0;
      tgt_blu  <= '0;
      for (int k = 0; k < 8; k++) begin
        tbl[k] <= default_entry(3'(k));
      end
    end else begin
      // Target latches below read the pre-write table contents.
      if (LOAD_WE) begin
        tbl[LOAD_ADDR] <= LOAD_DATA;
      end
      if (!EN) begin
        state <= IDLE;
        BUSY  <= 1'b0;
        pre   <= '0;
      end else begin
        pre <= ((state == IDLE) || tick) ? '0 : pre + PW'(1);
        case (state)
          IDLE: begin
            state   <= FADE;
            BUSY    <= 1'b1;
            tgt_red <= entry_now[3*W-1:2*W];
            tgt_grn <= entry_now[2*W-1:W];
            tgt_blu <= entry_now[W-1:0];
          end
          FADE: begin
            if (at_tgt) begin
              state <= HOLD;
              hold  <= '0;
            end else if (tick) begin
              cur_red <= approach(cur_red, tgt_red);
              cur_grn <= approach(cur_grn, tgt_grn);
              cur_blu <= approach(cur_blu, tgt_blu);
            end
          end
          HOLD: begin
            if (tick) begin
              if (hold == HOLD_LAST) begin
                state    <= FADE;
                hold     <= '0;
                STEP_IDX <= next_idx;
                tgt_red  <= entry_next[3*W-1:2*W];
                tgt_grn  <= entry_next[2*W-1:W];
                tgt_blu  <= entry_next[W-1:0];
              end else begin
                hold <= hold + HW'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_fade_sched.sv
// Directed, scoreboard-driven bench for led_fade_sched at W=4, PRESCALE=2,
// HOLD_TICKS=3, STEP=5.
module tb_led_fade_sched;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        EN = 1'b0;
  logic        LOAD_WE = 1'b0;
  logic [2:0]  LOAD_ADDR = 3'd0;
  logic [11:0] LOAD_DATA = 12'h000;
  logic [2:0]  LEDs;
  logic        BUSY;
  logic [2:0]  STEP_IDX;

  int errors = 0;
  int checks = 0;
  int n;
  int lows;
  int others;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  // Current duties {R,G,B}, observed inside the design.
  wire [11:0] rgb = {dut.cur_red, dut.cur_grn, dut.cur_blu};

  led_fade_sched #(
    .PWM_WIDTH (4),
    .PRESCALE  (2),
    .HOLD_TICKS(3),
    .STEP      (5)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .EN       (EN),
    .LOAD_WE  (LOAD_WE),
    .LOAD_ADDR(LOAD_ADDR),
    .LOAD_DATA(LOAD_DATA),
    .LEDs     (LEDs),
    .BUSY     (BUSY),
    .STEP_IDX (STEP_IDX)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_underflow";
      e.val = 16'hxxxx;
    end else begin
      e = sb.pop_front();
    end
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic flush();
    while (sb.size() > 0) check(16'hxxxx);
  endtask

  task automatic step(input int cycles = 1);
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Pops one expected {R,G,B} per observed duty change; optionally rewrites
  // table[2] the first time STEP_IDX shows 2.
  task automatic watch_rgb(input int budget, input bit poke2);
    logic [11:0] prev;
    bit          poked;
    prev  = rgb;
    poked = 1'b0;
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      step();
      LOAD_WE = 1'b0;
      if (poke2 && !poked && STEP_IDX == 3'd2) begin
        LOAD_WE   = 1'b1;
        LOAD_ADDR = 3'd2;
        LOAD_DATA = 12'h333;
        poked     = 1'b1;
      end
      if (rgb !== prev) begin
        check({4'h0, rgb});
        prev = rgb;
      end
    end
    LOAD_WE = 1'b0;
    flush();
  endtask

  task automatic wait_idx(input logic [2:0] idx, input int budget, output int cycles);
    cycles = 0;
    while (STEP_IDX !== idx && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic count_lows(input int cycles, output int r_low, output int gb_on);
    r_low = 0;
    gb_on = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (LEDs[0] == 1'b0) r_low++;
      if (LEDs[2:1] != 2'b11) gb_on++;
    end
  endtask

  initial begin
    // Reset, then idle with EN low.
    step(3);
    expect_val("reset_outputs", 16'h0070);
    check({9'h0, LEDs, BUSY, STEP_IDX});
    nRST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      expect_val("idle_en_low", 16'h0070);
      check({9'h0, LEDs, BUSY, STEP_IDX});
    end

    // Black entry 0 goes straight to HOLD, then entry 1 ramps red up.
    EN = 1'b1;
    step();
    expect_val("busy_after_en", 16'h0008);
    check({12'h0, BUSY, STEP_IDX});
    wait_idx(3'd1, 30, n);
    expect_val("first_hold_cycles", 16'd6);
    check(16'(n));
    expect_val("ramp_r5", 16'h0500);
    expect_val("ramp_r10", 16'h0A00);
    expect_val("ramp_r15", 16'h0F00);
    watch_rgb(40, 1'b0);
    EN = 1'b0;
    step();
    expect_val("idle_after_drop", 16'h0001);
    check({12'h0, BUSY, STEP_IDX});
    step(20);
    count_lows(30, lows, others);
    expect_val("r_full_on_lows", 16'd30);
    check(16'(lows));
    expect_val("gb_stay_off", 16'd0);
    check(16'(others));

    // Partial duty 7 on red.
    LOAD_WE = 1'b1; LOAD_ADDR = 3'd1; LOAD_DATA = 12'h700;
    step();
    LOAD_WE = 1'b0;
    EN = 1'b1;
    expect_val("down_r10", 16'h0A00);
    expect_val("down_r7_clamped", 16'h0700);
    watch_rgb(40, 1'b0);
    EN = 1'b0;
    step();
    expect_val("idle_at_r7", 16'h0001);
    check({12'h0, BUSY, STEP_IDX});
    step(20);
    count_lows(15, lows, others);
    expect_val("r7_lows_window1", 16'd7);
    check(16'(lows));
    count_lows(15, lows, others);
    expect_val("r7_lows_window2", 16'd7);
    check(16'(lows));

    // Write and latch of the same entry in one cycle: the old colour wins.
    EN = 1'b1;
    LOAD_WE = 1'b1; LOAD_ADDR = 3'd1; LOAD_DATA = 12'hF00;
    step();
    LOAD_WE = 1'b0;
    expect_val("busy_same_cycle_wr", 16'h0009);
    check({12'h0, BUSY, STEP_IDX});
    step(3);
    expect_val("old_target_latched", 16'h1700);
    check({1'b0, STEP_IDX, rgb});
    EN = 1'b0;
    step();
    expect_val("idle_again", 16'h0001);
    check({12'h0, BUSY, STEP_IDX});

    // Cross-fade red->green; table[2] rewritten after it is latched.
    EN = 1'b1;
    expect_val("up_r12", 16'h0C00);
    expect_val("up_r15", 16'h0F00);
    expect_val("xfade_1", 16'h0A50);
    expect_val("xfade_2", 16'h05A0);
    expect_val("xfade_3", 16'h00F0);
    watch_rgb(80, 1'b1);
    wait_idx(3'd3, 20, n);
    expect_val("hold_after_xfade", 16'd6);
    check(16'(n));

    // Drop EN mid-fade at R=10, then resume.
    expect_val("y_r5", 16'h05F0);
    expect_val("y_r10", 16'h0AF0);
    watch_rgb(40, 1'b0);
    EN = 1'b0;
    step();
    expect_val("frozen_busy_low", 16'h0AF0);
    check({3'h0, BUSY, rgb});
    step(10);
    expect_val("frozen_hold", 16'h3AF0);
    check({BUSY, STEP_IDX, rgb});
    EN = 1'b1;
    expect_val("resume_r15", 16'h0FF0);
    watch_rgb(20, 1'b0);

    // Reset in HOLD at index 7 restores table defaults.
    LOAD_WE = 1'b1; LOAD_ADDR = 3'd0; LOAD_DATA = 12'hFFF;
    step();
    LOAD_WE = 1'b0;
    wait_idx(3'd7, 600, n);
    expect_val("reach_idx7", 16'd1);
    check(16'(n < 600));
    n = 0;
    while (rgb !== 12'hFFF && n < 60) begin
      step();
      n++;
    end
    step(2);
    expect_val("idx7_white_hold", 16'h7FFF);
    check({1'b0, STEP_IDX, rgb});
    nRST = 1'b0;
    step();
    expect_val("reset_mid_hold", 16'h0070);
    check({9'h0, LEDs, BUSY, STEP_IDX});
    nRST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_val("table0_default_black", 16'h7000);
      check({1'b0, LEDs, rgb});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
